// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register write arbiter: FSM encoding and width helpers.
package reg_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Requester index width, never narrower than one bit.
  function automatic int unsigned ow_width(input int unsigned n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request scanning upward from start, wrapping modulo N_REQ.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned OW    = ow_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    start,
  output logic             found_c,
  output logic [OW-1:0]    winner_c
);

  // Scan from the far end backwards so the lowest offset from start wins.
  always_comb begin
    int idx;
    found_c  = 1'b0;
    winner_c = '0;
    idx      = 0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % int'(N_REQ);
      if (req[idx]) begin
        found_c  = 1'b1;
        winner_c = OW'(idx);
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register among N_REQ writers with a bounded hold per owner.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int unsigned N_REQ    = 4,
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned MAX_HOLD = 4,
  localparam int unsigned OW       = ow_width(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic [OW-1:0]          q_owner,
  output logic                   q_valid,
  output logic                   busy
);

  localparam int unsigned HW = clog2(MAX_HOLD + 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [OW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [OW-1:0]    q_owner_q, q_owner_d;
  logic             q_valid_q, q_valid_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] wd [N_REQ];
  logic [OW-1:0]    owner_c;
  logic [OW-1:0]    next_idx_c;
  logic [OW-1:0]    start_c;
  logic             found_c;
  logic [OW-1:0]    winner_c;
  logic             xfer_c;
  logic             release_c;

  for (genvar g = 0; g < int'(N_REQ); g++) begin : g_unpack
    assign wd[g] = wdata[g*WIDTH +: WIDTH];
  end

  // Current owner index from the one-hot grant.
  always_comb begin
    owner_c = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (gnt_q[i]) owner_c = OW'(i);
    end
  end

  assign next_idx_c = (owner_c == OW'(N_REQ - 1)) ? '0 : owner_c + OW'(1);
  assign start_c    = (state_q == IDLE) ? rr_ptr_q : next_idx_c;
  assign xfer_c     = (state_q == OWN) && (|(req & gnt_q));
  assign release_c  = (state_q == OWN) &&
                      (!xfer_c || ((hold_cnt_q + HW'(1)) == HW'(MAX_HOLD)));

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req      (req),
    .start    (start_c),
    .found_c  (found_c),
    .winner_c (winner_c)
  );

  // Next-state, grant and storage update.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    hold_cnt_d = hold_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    q_d        = q_q;
    q_owner_d  = q_owner_q;
    q_valid_d  = q_valid_q;

    case (state_q)
      IDLE: begin
        if (found_c) begin
          gnt_d           = '0;
          gnt_d[winner_c] = 1'b1;
          hold_cnt_d      = '0;
          state_d         = OWN;
        end
      end
      OWN: begin
        if (xfer_c) begin
          q_d        = wd[owner_c];
          q_owner_d  = owner_c;
          q_valid_d  = 1'b1;
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
        // Handoff goes straight to the next winner with no idle cycle.
        if (release_c) begin
          rr_ptr_d   = next_idx_c;
          hold_cnt_d = '0;
          gnt_d      = '0;
          if (found_c) begin
            gnt_d[winner_c] = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      hold_cnt_q <= '0;
      rr_ptr_q   <= '0;
      q_q        <= '0;
      q_owner_q  <= '0;
      q_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      hold_cnt_q <= hold_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      q_q        <= q_d;
      q_owner_q  <= q_owner_d;
      q_valid_q  <= q_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign q       = q_q;
  assign q_owner = q_owner_q;
  assign q_valid = q_valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed and random checks of reg_write_arbiter against a transaction-level fairness model.
module tb_reg_write_arbiter;

  localparam int N_REQ    = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       q;
  logic [1:0]             q_owner;
  logic                   q_valid;
  logic                   busy;

  int total = 0;
  int bad   = 0;

  // Model: who owns the register, how many writes in this tenure, where the next scan starts.
  int   m_owner;
  int   m_cnt;
  int   m_rr;
  int   m_q;
  int   m_qown;
  bit   m_qv;

  reg_write_arbiter #(
    .N_REQ    (N_REQ),
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .q       (q),
    .q_owner (q_owner),
    .q_valid (q_valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int scan(input logic [N_REQ-1:0] r, input int start);
    for (int k = 0; k < N_REQ; k++) begin
      if (r[(start + k) % N_REQ]) return (start + k) % N_REQ;
    end
    return -1;
  endfunction

  function automatic void model_edge(input logic [N_REQ-1:0] r, input logic [N_REQ*WIDTH-1:0] w,
                                     input logic rs);
    int o;
    bit wrote;
    if (!rs) begin
      m_owner = -1; m_cnt = 0; m_rr = 0; m_q = 0; m_qown = 0; m_qv = 0;
    end else if (m_owner < 0) begin
      m_owner = scan(r, m_rr);
      m_cnt   = 0;
    end else begin
      o     = m_owner;
      wrote = r[o];
      if (wrote) begin
        m_q    = int'(w[o*WIDTH +: WIDTH]);
        m_qown = o;
        m_qv   = 1;
        m_cnt++;
      end
      if (!wrote || m_cnt == MAX_HOLD) begin
        m_rr    = (o + 1) % N_REQ;
        m_owner = scan(r, m_rr);
        m_cnt   = 0;
      end
    end
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare all outputs.
  task automatic step();
    logic [N_REQ-1:0]       r;
    logic [N_REQ*WIDTH-1:0] w;
    logic                   rs;
    logic [N_REQ-1:0]       eg;
    r  = req;
    w  = wdata;
    rs = rst;
    @(posedge clk);
    model_edge(r, w, rs);
    #1;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    check("gnt", 32'(gnt), 32'(eg));
    check("busy", 32'(busy), 32'(eg != 0));
    check("q_valid", 32'(q_valid), 32'(m_qv));
    check("q", 32'(q), 32'(m_q));
    if (m_qv) check("q_owner", 32'(q_owner), 32'(m_qown));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    int owners [$];
    m_owner = -1; m_cnt = 0; m_rr = 0; m_q = 0; m_qown = 0; m_qv = 0;

    // Reset with every requester active.
    rst   = 1'b0;
    req   = 4'b1111;
    wdata = {4{8'hFF}};
    step();
    step();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_q", 32'(q), 32'h0);
    check("rst_qv", 32'(q_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // Single writer latency.
    rst   = 1'b1;
    req   = 4'b0001;
    wdata = 32'h0000_00A5;
    step();
    check("single_gnt1", 32'(gnt), 32'h1);
    check("single_qv1", 32'(q_valid), 32'h0);
    step();
    check("single_q2", 32'(q), 32'hA5);
    check("single_own2", 32'(q_owner), 32'h0);
    check("single_qv2", 32'(q_valid), 32'h1);

    // Hold limit alternation between two persistent requesters.
    do_reset();
    req   = 4'b0011;
    wdata = 32'h0000_2211;
    step();
    check("hold_gnt_k1", 32'(gnt), 32'h1);
    for (int k = 2; k <= 17; k++) begin
      step();
      check("hold_gnt", 32'(gnt), (((k - 1) / 4) % 2 != 0) ? 32'h2 : 32'h1);
      check("hold_q", 32'(q), (((k - 2) / 4) % 2 != 0) ? 32'h22 : 32'h11);
    end

    // Fairness: each owner briefly drops after its first write.
    do_reset();
    req   = 4'b1111;
    wdata = 32'h4433_2211;
    step();
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < N_REQ; i++) if (gnt[i]) owners.push_back(i);
      step();
      req = 4'b1111 & ~gnt;
      step();
      req = 4'b1111;
    end
    check("fair_len", 32'(owners.size()), 32'd5);
    for (int n = 0; n < 5 && n < owners.size(); n++) check("fair_order", 32'(owners[n]), 32'(n % N_REQ));

    // Early drop hands off without writing.
    do_reset();
    req   = 4'b0100;
    wdata = 32'h4433_5A11;
    step();
    step();
    check("drop_q_before", 32'(q), 32'h33);
    wdata = 32'h77_66_55_44;
    req   = 4'b1000;
    step();
    check("drop_q_hold", 32'(q), 32'h33);
    check("drop_gnt", 32'(gnt), 32'h8);
    check("drop_rr", 32'(dut.rr_ptr_q), 32'd3);

    // Reset mid-tenure, then re-arbitration from index 0.
    do_reset();
    req = 4'b0010;
    step();
    req = 4'b0100;
    step();
    check("mid_gnt_pre", 32'(gnt), 32'h4);
    wdata = 32'h003C_0000;
    rst   = 1'b0;
    step();
    check("mid_gnt", 32'(gnt), 32'h0);
    check("mid_q", 32'(q), 32'h0);
    check("mid_qv", 32'(q_valid), 32'h0);
    check("mid_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    req = 4'b1010;
    step();
    check("mid_rearb", 32'(gnt), 32'h2);

    // Random traffic with sticky requests and rare resets.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      wdata = $urandom;
      rst   = ($urandom_range(0, 79) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
